// File: rtl/sound_pkg.sv
// Shared definitions for the sound unit channels: duty encodings, duty
// waveforms and default field widths.
package sound_pkg;

    localparam int unsigned FREQ_W_DEF = 11;
    localparam int unsigned VOL_W_DEF  = 4;
    localparam int unsigned LEN_W_DEF  = 6;
    localparam int unsigned ENV_W_DEF  = 3;

    typedef enum logic [1:0] {
        DUTY_12_5 = 2'b00,
        DUTY_25   = 2'b01,
        DUTY_50   = 2'b10,
        DUTY_75   = 2'b11
    } duty_e;

    // Bit n of a pattern is the output level during sequencer step n.
    localparam logic [7:0] DUTY_PAT_12_5 = 8'b1000_0000;
    localparam logic [7:0] DUTY_PAT_25   = 8'b1000_0001;
    localparam logic [7:0] DUTY_PAT_50   = 8'b1110_0001;
    localparam logic [7:0] DUTY_PAT_75   = 8'b0111_1110;

    function automatic logic duty_bit(input duty_e duty, input logic [2:0] step);
        logic [7:0] pat;
        pat = DUTY_PAT_12_5;
        case (duty)
            DUTY_12_5: pat = DUTY_PAT_12_5;
            DUTY_25:   pat = DUTY_PAT_25;
            DUTY_50:   pat = DUTY_PAT_50;
            DUTY_75:   pat = DUTY_PAT_75;
            default:   pat = DUTY_PAT_12_5;
        endcase
        return pat[step];
    endfunction

endpackage

// File: rtl/square_channel_if.sv
// Control and sample bus of one pulse channel; master drives the controls,
// slave is the channel.
interface square_channel_if
    import sound_pkg::*;
#(
    parameter int unsigned FREQ_W = FREQ_W_DEF,
    parameter int unsigned VOL_W  = VOL_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF,
    parameter int unsigned ENV_W  = ENV_W_DEF
) ();

    logic [FREQ_W-1:0] I_FREQUENCY;
    logic [1:0]        I_DUTY_CYCLE;
    logic              I_TRIGGER;
    logic [VOL_W-1:0]  I_INIT_VOL;
    logic              I_ENV_UP;
    logic [ENV_W-1:0]  I_ENV_PERIOD;
    logic [LEN_W-1:0]  I_LENGTH;
    logic              I_LENGTH_EN;
    logic              I_LEN_TICK;
    logic              I_ENV_TICK;
    logic              I_WAVEFORM_EN;
    logic              O_WAVE;
    logic [VOL_W-1:0]  O_SAMPLE;
    logic              O_ACTIVE;

    modport master (
        output I_FREQUENCY, I_DUTY_CYCLE, I_TRIGGER, I_INIT_VOL, I_ENV_UP,
               I_ENV_PERIOD, I_LENGTH, I_LENGTH_EN, I_LEN_TICK, I_ENV_TICK,
               I_WAVEFORM_EN,
        input  O_WAVE, O_SAMPLE, O_ACTIVE
    );

    modport slave (
        input  I_FREQUENCY, I_DUTY_CYCLE, I_TRIGGER, I_INIT_VOL, I_ENV_UP,
               I_ENV_PERIOD, I_LENGTH, I_LENGTH_EN, I_LEN_TICK, I_ENV_TICK,
               I_WAVEFORM_EN,
        output O_WAVE, O_SAMPLE, O_ACTIVE
    );

endinterface

// File: rtl/sound_envelope.sv
// Volume register with a periodic up/down envelope; shared by the pulse and
// noise channels.
module sound_envelope
    import sound_pkg::*;
#(
    parameter int unsigned VOL_W = VOL_W_DEF,
    parameter int unsigned ENV_W = ENV_W_DEF
) (
    input  logic             I_CLK,
    input  logic             I_RESET,
    input  logic             I_TRIGGER,
    input  logic [VOL_W-1:0] I_INIT_VOL,
    input  logic             I_ENV_UP,
    input  logic [ENV_W-1:0] I_ENV_PERIOD,
    input  logic             I_ENV_TICK,
    output logic [VOL_W-1:0] O_VOLUME
);

    localparam logic [VOL_W-1:0] VOL_MAX = {VOL_W{1'b1}};

    logic [VOL_W-1:0] volume_q;
    logic [ENV_W-1:0] period_q;
    logic [ENV_W-1:0] count_q;
    logic             up_q;

    // Trigger reloads everything and swallows a coincident envelope tick.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            volume_q <= '0;
            period_q <= '0;
            count_q  <= '0;
            up_q     <= 1'b0;
        end else if (I_TRIGGER) begin
            volume_q <= I_INIT_VOL;
            period_q <= I_ENV_PERIOD;
            count_q  <= I_ENV_PERIOD;
            up_q     <= I_ENV_UP;
        end else if (I_ENV_TICK && (period_q != '0)) begin
            if (count_q <= ENV_W'(1)) begin
                count_q <= period_q;
                if (up_q && (volume_q != VOL_MAX)) begin
                    volume_q <= volume_q + VOL_W'(1);
                end else if (!up_q && (volume_q != '0)) begin
                    volume_q <= volume_q - VOL_W'(1);
                end
            end else begin
                count_q <= count_q - ENV_W'(1);
            end
        end
    end

    assign O_VOLUME = volume_q;

endmodule

// File: rtl/square_channel.sv
// Pulse (square) tone channel: prescaled period timer driving an 8-step duty
// sequencer, with length counter and volume envelope.
module square_channel
    import sound_pkg::*;
#(
    parameter int unsigned FREQ_W   = FREQ_W_DEF,
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned VOL_W    = VOL_W_DEF,
    parameter int unsigned LEN_W    = LEN_W_DEF,
    parameter int unsigned ENV_W    = ENV_W_DEF
) (
    input  logic           I_CLK,
    input  logic           I_RESET,
    square_channel_if.slave bus
);

    localparam int unsigned TMR_W = FREQ_W + 1;
    localparam int unsigned CNT_W = LEN_W + 1;
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0] prescale_q;
    logic [TMR_W-1:0] timer_q;
    logic [2:0]       step_q;
    logic [CNT_W-1:0] length_q;
    logic             active_q;
    logic [VOL_W-1:0] volume;

    logic             dec_tick_c;
    logic [TMR_W-1:0] reload_c;
    logic [CNT_W-1:0] length_load_c;
    logic             wave_c;

    assign dec_tick_c    = (prescale_q == PRE_W'(PRESCALE - 1));
    assign reload_c      = {1'b1, {FREQ_W{1'b0}}} - {1'b0, bus.I_FREQUENCY};
    assign length_load_c = {1'b1, {LEN_W{1'b0}}} - {1'b0, bus.I_LENGTH};

    // Prescaler, period timer and step sequencer. Frequency is only sampled
    // at reload, so a mid-note change never shortens the current step.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            prescale_q <= '0;
            timer_q    <= '0;
            step_q     <= '0;
        end else if (bus.I_TRIGGER) begin
            prescale_q <= '0;
            timer_q    <= reload_c;
            step_q     <= '0;
        end else begin
            prescale_q <= dec_tick_c ? '0 : prescale_q + PRE_W'(1);
            if (dec_tick_c) begin
                if (timer_q == TMR_W'(1)) begin
                    timer_q <= reload_c;
                    step_q  <= step_q + 3'd1;
                end else begin
                    timer_q <= timer_q - TMR_W'(1);
                end
            end
        end
    end

    // Length counter and enable status; a trigger reloads the length only
    // once the previous note has run out.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            length_q <= '0;
            active_q <= 1'b0;
        end else if (bus.I_TRIGGER) begin
            if (length_q == '0) begin
                length_q <= length_load_c;
            end
            active_q <= (bus.I_INIT_VOL != '0) || bus.I_ENV_UP;
        end else if (bus.I_LEN_TICK && bus.I_LENGTH_EN && (length_q != '0)) begin
            length_q <= length_q - CNT_W'(1);
            if (length_q == CNT_W'(1)) begin
                active_q <= 1'b0;
            end
        end
    end

    sound_envelope #(
        .VOL_W (VOL_W),
        .ENV_W (ENV_W)
    ) u_envelope (
        .I_CLK        (I_CLK),
        .I_RESET      (I_RESET),
        .I_TRIGGER    (bus.I_TRIGGER),
        .I_INIT_VOL   (bus.I_INIT_VOL),
        .I_ENV_UP     (bus.I_ENV_UP),
        .I_ENV_PERIOD (bus.I_ENV_PERIOD),
        .I_ENV_TICK   (bus.I_ENV_TICK),
        .O_VOLUME     (volume)
    );

    // Duty select is applied live so a duty change shows up on the next cycle.
    always_comb begin
        wave_c = 1'b0;
        if (active_q && bus.I_WAVEFORM_EN) begin
            wave_c = duty_bit(duty_e'(bus.I_DUTY_CYCLE), step_q);
        end
    end

    assign bus.O_WAVE   = wave_c;
    assign bus.O_SAMPLE = wave_c ? volume : '0;
    assign bus.O_ACTIVE = active_q;

endmodule

// File: tb/tb_square_channel.sv
// Directed and randomized bench for square_channel against a cycle-count
// reference model of the tone, length and envelope rules.
module tb_square_channel;

    localparam int unsigned FREQ_W   = 11;
    localparam int unsigned PRESCALE = 4;
    localparam int unsigned VOL_W    = 4;
    localparam int unsigned LEN_W    = 6;
    localparam int unsigned ENV_W    = 3;
    localparam int          VOL_MAX  = (1 << VOL_W) - 1;

    logic I_CLK = 1'b0;
    logic I_RESET;

    square_channel_if #(.FREQ_W(FREQ_W), .VOL_W(VOL_W), .LEN_W(LEN_W), .ENV_W(ENV_W)) bus ();

    square_channel #(
        .FREQ_W(FREQ_W), .PRESCALE(PRESCALE), .VOL_W(VOL_W), .LEN_W(LEN_W), .ENV_W(ENV_W)
    ) dut (
        .I_CLK   (I_CLK),
        .I_RESET (I_RESET),
        .bus     (bus)
    );

    always #5 I_CLK = ~I_CLK;

    int tests = 0;
    int fails = 0;

    // Reference state: current step, clocks left in it, length, envelope.
    int m_step, m_left, m_len, m_vol, m_per, m_ctr;
    bit m_up, m_active;

    function automatic bit duty_high(input int d, input int s);
        case (d)
            0:       return s == 7;
            1:       return (s == 0) || (s == 7);
            2:       return (s == 0) || (s >= 5);
            default: return (s >= 1) && (s <= 6);
        endcase
    endfunction

    function automatic int step_clocks(input int f);
        return PRESCALE * ((1 << FREQ_W) - f);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (I_RESET) begin
            m_step = 0; m_left = 0; m_len = 0; m_vol = 0;
            m_per = 0; m_ctr = 0; m_up = 0; m_active = 0;
        end else if (bus.I_TRIGGER) begin
            m_step   = 0;
            m_left   = step_clocks(int'(bus.I_FREQUENCY));
            m_vol    = int'(bus.I_INIT_VOL);
            m_per    = int'(bus.I_ENV_PERIOD);
            m_ctr    = m_per;
            m_up     = bus.I_ENV_UP;
            if (m_len == 0) m_len = (1 << LEN_W) - int'(bus.I_LENGTH);
            m_active = (m_vol != 0) || m_up;
        end else begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_step = (m_step + 1) % 8;
                    m_left = step_clocks(int'(bus.I_FREQUENCY));
                end
            end
            if (bus.I_LEN_TICK && bus.I_LENGTH_EN && m_len != 0) begin
                m_len--;
                if (m_len == 0) m_active = 0;
            end
            if (bus.I_ENV_TICK && m_per != 0) begin
                m_ctr--;
                if (m_ctr == 0) begin
                    m_ctr = m_per;
                    if (m_up && m_vol < VOL_MAX) m_vol++;
                    else if (!m_up && m_vol > 0) m_vol--;
                end
            end
        end
    endtask

    // One clock: update the model from the inputs seen at the edge, drop the
    // one-cycle pulses, then compare all outputs.
    task automatic tick_clk();
        bit exp_wave;
        @(posedge I_CLK);
        model_edge();
        #1;
        bus.I_TRIGGER  = 1'b0;
        bus.I_LEN_TICK = 1'b0;
        bus.I_ENV_TICK = 1'b0;
        exp_wave = m_active && bus.I_WAVEFORM_EN && duty_high(int'(bus.I_DUTY_CYCLE), m_step);
        check("wave",   int'(bus.O_WAVE),   int'(exp_wave));
        check("sample", int'(bus.O_SAMPLE), exp_wave ? m_vol : 0);
        check("active", int'(bus.O_ACTIVE), int'(m_active));
    endtask

    task automatic count_high(input int n, output int hi, output int pk);
        hi = 0;
        pk = 0;
        for (int i = 0; i < n; i++) begin
            tick_clk();
            hi += int'(bus.O_WAVE);
            if (int'(bus.O_SAMPLE) > pk) pk = int'(bus.O_SAMPLE);
        end
    endtask

    task automatic setup(input int f, input int duty, input int vol, input bit up,
                         input int per, input int len, input bit len_en);
        bus.I_FREQUENCY  = FREQ_W'(f);
        bus.I_DUTY_CYCLE = 2'(duty);
        bus.I_INIT_VOL   = VOL_W'(vol);
        bus.I_ENV_UP     = up;
        bus.I_ENV_PERIOD = ENV_W'(per);
        bus.I_LENGTH     = LEN_W'(len);
        bus.I_LENGTH_EN  = len_en;
    endtask

    task automatic do_reset();
        I_RESET = 1'b1;
        tick_clk();
        I_RESET = 1'b0;
    endtask

    initial begin
        int hi, pk;
        I_RESET           = 1'b1;
        bus.I_TRIGGER     = 1'b0;
        bus.I_LEN_TICK    = 1'b0;
        bus.I_ENV_TICK    = 1'b0;
        bus.I_WAVEFORM_EN = 1'b0;
        setup(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick_clk();
        check("rst_active", int'(bus.O_ACTIVE), 0);
        check("rst_sample", int'(bus.O_SAMPLE), 0);
        I_RESET = 1'b0;
        bus.I_WAVEFORM_EN = 1'b1;

        // 50% duty at the fastest tone: 32-clock period, 16 high
        setup(2047, 2, 15, 0, 0, 0, 0);
        bus.I_TRIGGER = 1'b1;
        count_high(32, hi, pk);
        check("duty50_high", hi, 16);
        check("duty50_peak", pk, 15);
        bus.I_DUTY_CYCLE = 2'd0;
        count_high(32, hi, pk);
        check("duty12_high", hi, 4);
        bus.I_DUTY_CYCLE = 2'd3;
        count_high(32, hi, pk);
        check("duty75_high", hi, 24);
        bus.I_WAVEFORM_EN = 1'b0;
        count_high(32, hi, pk);
        check("gate_off_high", hi, 0);
        bus.I_WAVEFORM_EN = 1'b1;

        // Length 60 expires after four ticks
        do_reset();
        setup(2047, 3, 15, 0, 0, 60, 1);
        bus.I_TRIGGER = 1'b1;
        tick_clk();
        for (int i = 0; i < 4; i++) begin
            repeat (3) tick_clk();
            bus.I_LEN_TICK = 1'b1;
            tick_clk();
            if (i == 2) check("len_3_ticks", int'(bus.O_ACTIVE), 1);
        end
        check("len_expired", int'(bus.O_ACTIVE), 0);
        count_high(8, hi, pk);
        check("len_silent", pk, 0);

        // Length disabled: channel stays on
        do_reset();
        setup(2047, 3, 15, 0, 0, 60, 0);
        bus.I_TRIGGER = 1'b1;
        tick_clk();
        for (int i = 0; i < 10; i++) begin
            bus.I_LEN_TICK = 1'b1;
            tick_clk();
            tick_clk();
        end
        check("len_disabled", int'(bus.O_ACTIVE), 1);

        // Envelope down to zero, then saturates
        setup(2047, 3, 2, 0, 1, 0, 0);
        bus.I_TRIGGER = 1'b1;
        tick_clk();
        repeat (2) begin
            bus.I_ENV_TICK = 1'b1;
            tick_clk();
            tick_clk();
        end
        count_high(16, hi, pk);
        check("env_down_zero", pk, 0);
        bus.I_ENV_TICK = 1'b1;
        tick_clk();
        count_high(16, hi, pk);
        check("env_down_sat", pk, 0);
        check("env_down_active", int'(bus.O_ACTIVE), 1);

        // Envelope up saturates at full scale
        setup(2047, 3, 14, 1, 1, 0, 0);
        bus.I_TRIGGER = 1'b1;
        tick_clk();
        repeat (3) begin
            bus.I_ENV_TICK = 1'b1;
            tick_clk();
            tick_clk();
        end
        count_high(16, hi, pk);
        check("env_up_sat", pk, VOL_MAX);

        // DAC off trigger leaves the channel disabled
        setup(2047, 3, 0, 0, 0, 0, 0);
        bus.I_TRIGGER = 1'b1;
        tick_clk();
        check("dac_off", int'(bus.O_ACTIVE), 0);

        // Trigger with a coincident length tick: full fresh count of 54
        do_reset();
        setup(2047, 2, 15, 0, 0, 10, 1);
        bus.I_TRIGGER  = 1'b1;
        bus.I_LEN_TICK = 1'b1;
        tick_clk();
        for (int i = 0; i < 53; i++) begin
            bus.I_LEN_TICK = 1'b1;
            tick_clk();
        end
        check("trig_len_53", int'(bus.O_ACTIVE), 1);
        bus.I_LEN_TICK = 1'b1;
        tick_clk();
        check("trig_len_54", int'(bus.O_ACTIVE), 0);

        // Reset mid-note
        setup(2047, 3, 15, 0, 0, 10, 0);
        bus.I_TRIGGER = 1'b1;
        repeat (6) tick_clk();
        check("note_on", int'(bus.O_ACTIVE), 1);
        I_RESET = 1'b1;
        tick_clk();
        check("midrst_active", int'(bus.O_ACTIVE), 0);
        check("midrst_wave",   int'(bus.O_WAVE), 0);
        check("midrst_sample", int'(bus.O_SAMPLE), 0);
        I_RESET = 1'b0;

        // Frequency change mid-step: step 0 keeps 16 clocks, later steps 8
        setup(2044, 3, 15, 0, 0, 0, 0);
        bus.I_TRIGGER = 1'b1;
        hi = 0;
        for (int k = 0; k < 64; k++) begin
            if (k == 5) bus.I_FREQUENCY = FREQ_W'(2046);
            tick_clk();
            hi += int'(bus.O_WAVE);
        end
        check("freq_change_high", hi, 48);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(99) == 0) begin
                bus.I_TRIGGER    = 1'b1;
                bus.I_INIT_VOL   = VOL_W'($urandom);
                bus.I_ENV_UP     = 1'($urandom);
                bus.I_ENV_PERIOD = ENV_W'($urandom);
                bus.I_LENGTH     = LEN_W'($urandom_range(40, 63));
            end
            if ($urandom_range(49) == 0) bus.I_FREQUENCY = FREQ_W'($urandom_range(2040, 2047));
            if ($urandom_range(19) == 0) bus.I_DUTY_CYCLE = 2'($urandom);
            if ($urandom_range(199) == 0) bus.I_LENGTH_EN = 1'($urandom);
            bus.I_LEN_TICK    = ($urandom_range(11) == 0);
            bus.I_ENV_TICK    = ($urandom_range(11) == 0);
            bus.I_WAVEFORM_EN = ($urandom_range(15) != 0);
            I_RESET           = ($urandom_range(799) == 0);
            tick_clk();
        end
        I_RESET = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/square_channel.md
Name: square_channel

Overview:
- Parametrised successor to the single-pulse waveform generator. Computes the tone period arithmetically; no period lookup BRAM.
- Adds an 8-step duty sequencer, a length counter, a volume envelope and a trigger/restart handshake.
- Produces a multi-bit amplitude sample for the sound mixer. One instance per pulse channel (CH1/CH2) in the GBC sound unit.
- Length and envelope strobes come from the shared frame sequencer.

Parameters:
- FREQ_W, 11, width of the frequency code; reload value is 2^FREQ_W - I_FREQUENCY.
- PRESCALE, 4, I_CLK cycles per period-timer decrement (minimum 1).
- VOL_W, 4, amplitude/volume width.
- LEN_W, 6, length counter width.
- ENV_W, 3, envelope period width.

Ports:
- I_CLK  in  1  system clock; single clock domain.
- I_RESET  in  1  synchronous, active-high reset.
- I_FREQUENCY  in  FREQ_W  frequency code; sampled at every timer reload.
- I_DUTY_CYCLE  in  2  duty select; sampled live every cycle.
- I_TRIGGER  in  1  one-cycle restart pulse.
- I_INIT_VOL  in  VOL_W  initial volume; latched on trigger.
- I_ENV_UP  in  1  envelope direction (1 = increase); latched on trigger.
- I_ENV_PERIOD  in  ENV_W  envelope step period; 0 = frozen; latched on trigger.
- I_LENGTH  in  LEN_W  length load value; latched on trigger.
- I_LENGTH_EN  in  1  length counter enable; sampled live.
- I_LEN_TICK  in  1  length strobe (256 Hz), one cycle wide.
- I_ENV_TICK  in  1  envelope strobe (64 Hz), one cycle wide.
- I_WAVEFORM_EN  in  1  master output gate.
- O_WAVE  out  1  raw duty bit, ANDed with O_ACTIVE and I_WAVEFORM_EN.
- O_SAMPLE  out  VOL_W  amplitude: volume when O_WAVE is 1, else 0.
- O_ACTIVE  out  1  channel enabled status.

Behaviour:
- Reset: all state zero. O_ACTIVE=0, O_WAVE=0, O_SAMPLE=0, step=0, timer=0, prescaler=0, volume=0, length count=0.
- O_WAVE and O_SAMPLE are combinational from registered state, O_ACTIVE, I_WAVEFORM_EN and I_DUTY_CYCLE.
- I_WAVEFORM_EN=0 forces both outputs to 0; internal counters keep running.

Prescaler:
- Counts 0..PRESCALE-1 and wraps.
- Each wrap is a timer decrement tick.

Period timer (FREQ_W+1 bits):
- Applies the decrement tick only when the timer equals 1: reload with 2^FREQ_W - I_FREQUENCY and advance step mod 8 (7 wraps to 0).
- Otherwise the tick decrements the timer.
- Full period is 8*PRESCALE*(2^FREQ_W - f) clocks.

Duty high steps:
- 00 → step 7 only (12.5%).
- 01 → steps 0 and 7 (25%).
- 10 → steps 0, 5, 6, 7 (50%).
- 11 → steps 1 through 6 (75%).

Trigger (cycle t; effects visible at t+1):
- Prescaler is cleared, the timer is reloaded from I_FREQUENCY and step is set to 0.
- Volume loads I_INIT_VOL; the envelope counter loads I_ENV_PERIOD.
- Length count loads 2^LEN_W - I_LENGTH, but only if the current count is 0 (count 0 loads 2^LEN_W - I_LENGTH; I_LENGTH=0 gives 2^LEN_W).
- O_ACTIVE is set to 1, except when I_INIT_VOL==0 and I_ENV_UP==0 (DAC off): then O_ACTIVE is set to 0.

Length:
- On I_LEN_TICK with I_LENGTH_EN=1 and count≠0: decrement the count.
- The transition to 0 clears O_ACTIVE in the same update.
- Count 0 with a tick: no change.

Envelope:
- On I_ENV_TICK with latched period≠0: decrement the counter.
- When the counter reaches 0, reload it with the period and step the volume.
- Volume steps +1 if up and volume < 2^VOL_W-1; −1 if down and volume > 0; otherwise it saturates (no wrap).
- Latched period 0: volume frozen.

Simultaneous events:
- Trigger plus any tick in the same cycle: trigger wins and the tick is discarded.
- I_RESET overrides everything.
- Reset mid-note returns the channel to the reset state within one cycle.

Frequency change mid-note:
- Takes effect at the next reload only; no glitch in the current step.

Decomposition:
- Shared package sound_pkg holds:
  - duty encodings DUTY_12_5, DUTY_25, DUTY_50, DUTY_75;
  - 8-bit duty pattern constants;
  - default widths for FREQ_W, VOL_W, LEN_W, ENV_W.
- One natural sub-module, sound_envelope: volume register plus envelope counter. Reused by the noise channel.
- Timer, sequencer and length logic stay in square_channel.

Test Plan:
- PRESCALE=4, f=2047, duty 10, vol 15, trigger: O_WAVE period 32 clocks, high 16 clocks (steps 5–7, then step 0). O_SAMPLE toggles between 15 and 0.
- Same setup, duty 00 then 11: high 4 of 32 clocks, then high 24 of 32. Duty change applies on the next cycle without retrigger.
- I_LENGTH=60, I_LENGTH_EN=1: after 4 I_LEN_TICK pulses O_ACTIVE=0 and O_SAMPLE=0. With I_LENGTH_EN=0, the channel stays active indefinitely.
- I_INIT_VOL=2, down, period 1: after 2 I_ENV_TICK pulses volume=0 and a further tick keeps 0. I_INIT_VOL=14, up: saturates at 15.
- Trigger with I_INIT_VOL=0 and I_ENV_UP=0 → O_ACTIVE stays 0. Trigger coincident with I_LEN_TICK → length count equals the fresh load (tick discarded).
- I_RESET asserted mid-note → next cycle all outputs 0. I_FREQUENCY changed mid-period → current step length unchanged, next step uses the new reload.
